// File: rtl/kernel_axil_master.sv
// Single-outstanding AXI4-Lite initiator: one local command becomes one AXI4-Lite
// read or write. Returns data/response and flags transactions that outlast C_TIMEOUT.
module kernel_axil_master #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_TIMEOUT    = 1024
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      timeout_err,
  input  logic                      timeout_clr,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [C_ADDR_WIDTH-1:0]   awaddr,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [C_DATA_WIDTH-1:0]   wdata,
  output logic [C_DATA_WIDTH/8-1:0] wstrb,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [C_ADDR_WIDTH-1:0]   araddr,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [C_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                rresp
);

  localparam int SW = C_DATA_WIDTH / 8;
  localparam int CW = $clog2(C_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                  state_reg, state_next;
  logic                    awvalid_reg, awvalid_next;
  logic                    wvalid_reg, wvalid_next;
  logic                    bready_reg, bready_next;
  logic                    arvalid_reg, arvalid_next;
  logic                    rready_reg, rready_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic [C_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [C_DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [SW-1:0]           wstrb_reg, wstrb_next;
  logic                    write_reg, write_next;
  logic [C_DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [1:0]              resp_reg, resp_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic                    terr_reg, terr_next;
  logic                    active;
  logic                    fire;

  assign cmd_ready   = ~areset & (state_reg == IDLE);
  assign awvalid     = awvalid_reg;
  assign wvalid      = wvalid_reg;
  assign bready      = bready_reg;
  assign arvalid     = arvalid_reg;
  assign rready      = rready_reg;
  assign awaddr      = addr_reg;
  assign araddr      = addr_reg;
  assign wdata       = wdata_reg;
  assign wstrb       = wstrb_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_write   = write_reg;
  assign rsp_rdata   = rdata_reg;
  assign rsp_resp    = resp_reg;
  assign timeout_err = terr_reg;

  assign active = (state_reg == WR_REQ) || (state_reg == WR_RESP) ||
                  (state_reg == RD_ADDR) || (state_reg == RD_DATA);
  // The error fires on the same edge the counter lands on C_TIMEOUT.
  assign fire   = active && (cnt_reg == CW'(C_TIMEOUT - 1));

  always_comb begin
    state_next     = state_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    rsp_valid_next = rsp_valid_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    write_next     = write_reg;
    rdata_next     = rdata_reg;
    resp_next      = resp_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          wstrb_next = cmd_wstrb;
          write_next = cmd_write;
          if (cmd_write) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = WR_REQ;
          end else begin
            arvalid_next = 1'b1;
            state_next   = RD_ADDR;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave once neither is pending.
        if (awvalid_reg && awready) awvalid_next = 1'b0;
        if (wvalid_reg && wready)   wvalid_next  = 1'b0;
        if (!awvalid_next && !wvalid_next) begin
          bready_next = 1'b1;
          state_next  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          resp_next      = bresp;
          rdata_next     = '0;
          bready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RSP;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rdata_next     = rdata;
          resp_next      = rresp;
          rready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next = '0;
    if (active)
      cnt_next = (cnt_reg == CW'(C_TIMEOUT)) ? cnt_reg : cnt_reg + CW'(1);
    terr_next = fire ? 1'b1 : (timeout_clr ? 1'b0 : terr_reg);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg     <= IDLE;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      write_reg     <= 1'b0;
      rdata_reg     <= '0;
      resp_reg      <= '0;
      cnt_reg       <= '0;
      terr_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      rsp_valid_reg <= rsp_valid_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      write_reg     <= write_next;
      rdata_reg     <= rdata_next;
      resp_reg      <= resp_next;
      cnt_reg       <= cnt_next;
      terr_reg      <= terr_next;
    end
  end

endmodule
